// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, variable-latency memory between the instruction-fetch
// port and the data (load/store) port. One access is in flight at a time; data
// wins contention unless fetch has been passed over STARVE_LIMIT times in a row.
// An optional watchdog aborts accesses that never see m_ack.
//
// Parameters:
//   STARVE_LIMIT  consecutive contended data grants before fetch must win (>=1)
//   TIMEOUT       cycles to wait for m_ack before abort; 0 disables watchdog
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   f_req/f_addr          fetch request and address
//   f_rvalid/f_rdata      fetch completion pulse and instruction
//   d_req/d_we/d_addr/    data request, store flag, address,
//   d_wdata/d_size        store data, funct3 size code
//   d_rvalid/d_rdata      data completion pulse and load data (0 for stores)
//   m_req/m_we/m_addr/    memory request and access fields
//   m_wdata/m_size
//   m_ack/m_rdata         memory completion and read data
//   stall_f, stall_d      combinational stalls to the hazard logic
//   err                   sticky watchdog flag
//
// state | meaning
// IDLE  | no access in flight, arbitrating requests
// FETCH | fetch access presented to memory, waiting for m_ack
// DATA  | data access presented to memory, waiting for m_ack
// RESP  | owning port's rvalid is high for this single cycle
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_size,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        stall_f,
    output logic        stall_d,
    output logic        err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    // Keep the watchdog counter at least one bit wide when it is disabled.
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(TIMEOUT);
    localparam logic          WDOG_EN    = (TIMEOUT > 0);
    localparam logic [31:0]   ABORT_DATA = 32'hDEAD_BEEF;
    localparam logic [2:0]    SIZE_WORD  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [SW-1:0]   starve_cnt;
    logic [WW-1:0]   wait_cnt;
    logic            fetch_wins;
    logic            timed_out;

    // Fetch wins when it is alone, or when data has starved it long enough.
    assign fetch_wins = f_req && (!d_req || (starve_cnt == STARVE_MAX));
    assign timed_out  = WDOG_EN && !m_ack && (wait_cnt == WAIT_MAX);

    assign stall_f = f_req & ~f_rvalid;
    assign stall_d = d_req & ~d_rvalid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_size     <= '0;
            f_rvalid   <= 1'b0;
            f_rdata    <= '0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            err        <= 1'b0;
        end else begin
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_wins) begin
                        state      <= FETCH;
                        m_req      <= 1'b1;
                        m_we       <= 1'b0;
                        m_addr     <= f_addr;
                        m_size     <= SIZE_WORD;
                        wait_cnt   <= '0;
                        starve_cnt <= '0;
                    end else if (d_req) begin
                        state    <= DATA;
                        m_req    <= 1'b1;
                        m_we     <= d_we;
                        m_addr   <= d_addr;
                        m_wdata  <= d_wdata;
                        m_size   <= d_size;
                        wait_cnt <= '0;
                        if (f_req) begin
                            if (starve_cnt != STARVE_MAX)
                                starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            starve_cnt <= '0;
                        end
                    end
                end
                FETCH, DATA: begin
                    if (m_ack || timed_out) begin
                        state <= RESP;
                        m_req <= 1'b0;
                        if (state == FETCH) begin
                            f_rvalid <= 1'b1;
                            f_rdata  <= m_ack ? m_rdata : ABORT_DATA;
                        end else begin
                            d_rvalid <= 1'b1;
                            if (!m_ack)
                                d_rdata <= ABORT_DATA;
                            else
                                d_rdata <= m_we ? 32'h0 : m_rdata;
                        end
                        if (!m_ack)
                            err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Requests are deliberately not sampled here.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_size;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_size;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        stall_f;
    logic        stall_d;
    logic        err;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(5)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_size(m_size), .m_ack(m_ack), .m_rdata(m_rdata),
        .stall_f(stall_f), .stall_d(stall_d), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_mreq(input int bound);
        for (int i = 0; i < bound && !m_req; i++) tick();
        chk("wait_m_req", {31'd0, m_req}, 32'd1);
    endtask

    string  exp_order;
    string  got_order;
    int     hi_cycles;

    initial begin
        reset = 1'b0; f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_size = 0; m_ack = 0; m_rdata = 0;
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("rst_m_req",   {31'd0, m_req}, 32'd0);
        chk("rst_err",     {31'd0, err}, 32'd0);
        chk("rst_m_addr",  m_addr, 32'h0);
        chk("rst_m_size",  {29'd0, m_size}, 32'd0);
        chk("rst_f_rdata", f_rdata, 32'h0);

        // Fetch, memory acks one cycle after m_req rises.
        f_req = 1; f_addr = 32'h100; #1;
        chk("t1_stall_f_c0", {31'd0, stall_f}, 32'd1);
        tick();
        chk("t1_m_req",  {31'd0, m_req}, 32'd1);
        chk("t1_m_we",   {31'd0, m_we}, 32'd0);
        chk("t1_m_size", {29'd0, m_size}, 32'd2);
        chk("t1_m_addr", m_addr, 32'h100);
        chk("t1_stall_f_c1", {31'd0, stall_f}, 32'd1);
        tick();
        chk("t1_rvalid_c2", {31'd0, f_rvalid}, 32'd0);
        chk("t1_stall_f_c2", {31'd0, stall_f}, 32'd1);
        m_ack = 1; m_rdata = 32'h0050_0093;
        tick();
        m_ack = 0;
        chk("t1_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("t1_f_rdata",  f_rdata, 32'h0050_0093);
        chk("t1_m_req_off", {31'd0, m_req}, 32'd0);
        chk("t1_stall_f_c3", {31'd0, stall_f}, 32'd0);
        f_req = 0;
        tick();
        chk("t1_rvalid_pulse", {31'd0, f_rvalid}, 32'd0);

        // Store, memory latency 3.
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hCAFE_F00D; d_size = 3'b000;
        tick();
        chk("t2_m_req",   {31'd0, m_req}, 32'd1);
        chk("t2_m_we",    {31'd0, m_we}, 32'd1);
        chk("t2_m_addr",  m_addr, 32'h200);
        chk("t2_m_wdata", m_wdata, 32'hCAFE_F00D);
        chk("t2_m_size",  {29'd0, m_size}, 32'd0);
        tick(); tick();
        chk("t2_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("t2_stall_d",   {31'd0, stall_d}, 32'd1);
        m_ack = 1; m_rdata = 32'h1234_5678;
        tick();
        m_ack = 0;
        chk("t2_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("t2_d_rdata",  d_rdata, 32'h0);
        chk("t2_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        d_req = 0;
        tick();

        // Both ports requesting continuously: fetch wins every fifth grant.
        exp_order = "DDDDFDDDDF";
        got_order = "";
        f_req = 1; f_addr = 32'h300;
        d_req = 1; d_we = 0; d_addr = 32'h400; d_size = 3'b010;
        for (int g = 0; g < 10; g++) begin
            wait_mreq(5);
            got_order = {got_order, (m_addr == 32'h300) ? "F" : "D"};
            m_ack = 1; m_rdata = 32'hA000_0000 + g;
            tick();
            m_ack = 0;
            if (exp_order[g] == "F") begin
                chk("t3_f_rvalid", {31'd0, f_rvalid}, 32'd1);
                chk("t3_f_rdata", f_rdata, 32'hA000_0000 + g);
            end else begin
                chk("t3_d_rvalid", {31'd0, d_rvalid}, 32'd1);
                chk("t3_d_rdata", d_rdata, 32'hA000_0000 + g);
            end
            tick();
        end
        checks++;
        assert (got_order == exp_order) else begin
            errors++;
            $error("FAIL t3_order observed=%s expected=%s", got_order, exp_order);
        end
        f_req = 0; d_req = 0;
        tick(); tick();

        // Watchdog: m_ack never comes. wait_cnt counts 0..5 before abort,
        // so m_req is visible for TIMEOUT+1 cycles.
        d_req = 1; d_we = 0; d_addr = 32'h500;
        tick();
        hi_cycles = 0;
        for (int i = 0; i < 20 && m_req; i++) begin
            hi_cycles++;
            tick();
        end
        chk("t4_m_req_cycles", hi_cycles, 32'd6);
        chk("t4_err",      {31'd0, err}, 32'd1);
        chk("t4_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("t4_d_rdata",  d_rdata, 32'hDEAD_BEEF);
        d_req = 0;
        tick();
        m_ack = 1;
        tick();
        m_ack = 0;
        chk("t4_late_ack_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("t4_late_ack_m_req",  {31'd0, m_req}, 32'd0);
        chk("t4_err_sticky",      {31'd0, err}, 32'd1);

        // Reset during a data access.
        d_req = 1; d_we = 1; d_addr = 32'h600; d_wdata = 32'h5555_AAAA;
        tick();
        chk("t5_m_req", {31'd0, m_req}, 32'd1);
        tick();
        reset = 0; d_req = 0;
        tick();
        reset = 1;
        chk("t5_m_req_off", {31'd0, m_req}, 32'd0);
        chk("t5_err_clr",   {31'd0, err}, 32'd0);
        chk("t5_d_rvalid",  {31'd0, d_rvalid}, 32'd0);
        chk("t5_d_rdata",   d_rdata, 32'h0);
        chk("t5_m_addr",    m_addr, 32'h0);
        m_ack = 1; m_rdata = 32'hFFFF_FFFF;
        tick();
        m_ack = 0;
        chk("t5_ack_ign_d", {31'd0, d_rvalid}, 32'd0);
        chk("t5_ack_ign_f", {31'd0, f_rvalid}, 32'd0);
        chk("t5_ack_ign_m", {31'd0, m_req}, 32'd0);
        f_req = 1; f_addr = 32'h700;
        tick();
        chk("t5_f_m_req",  {31'd0, m_req}, 32'd1);
        chk("t5_f_m_addr", m_addr, 32'h700);
        chk("t5_f_m_size", {29'd0, m_size}, 32'd2);
        m_ack = 1; m_rdata = 32'h0000_0013;
        tick();
        m_ack = 0; f_req = 0;
        chk("t5_f_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("t5_f_rdata",  f_rdata, 32'h0000_0013);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
